hwpe_stream_arbiter_rr: RTL

- Shares one registered HWPE stream output among NB_IN requester streams.
- Round-robin grant with a bounded burst: the owner keeps the output for up to MAX_BURST consecutive beats, then must rotate.
- Single output register stage: 1-cycle latency, full throughput, output stable under backpressure.
- Sits in front of a shared stream consumer, for example a streamer sink or a single-port buffer.

---
 rtl/hwpe_stream_arbiter_rr.sv | 114 +++++++++++
 1 files changed

// File: rtl/hwpe_stream_arbiter_rr.sv
// Round-robin arbiter sharing one registered HWPE stream output among NB_IN
// requesters; the owner may hold the output for up to MAX_BURST consecutive beats.
module hwpe_stream_arbiter_rr #(
  parameter int unsigned NB_IN      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 4,
  localparam int unsigned ID_W      = (NB_IN > 2) ? $clog2(NB_IN) : 1,
  localparam int unsigned STRB_W    = DATA_WIDTH / 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic [NB_IN-1:0]            push_valid_i,
  output logic [NB_IN-1:0]            push_ready_o,
  input  logic [NB_IN*DATA_WIDTH-1:0] push_data_i,
  input  logic [NB_IN*STRB_W-1:0]     push_strb_i,
  output logic                        pop_valid_o,
  input  logic                        pop_ready_i,
  output logic [DATA_WIDTH-1:0]       pop_data_o,
  output logic [STRB_W-1:0]           pop_strb_o,
  output logic [ID_W-1:0]             pop_id_o
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  logic                  pop_valid_q;
  logic [DATA_WIDTH-1:0] pop_data_q;
  logic [STRB_W-1:0]     pop_strb_q;
  logic [ID_W-1:0]       pop_id_q;
  logic [ID_W-1:0]       own_q;
  logic [CNT_W-1:0]      cnt_q;
  // Cleared by reset/clear so the very first grant comes from the scan
  // (starting at 0), while an owner returning after an idle load keeps priority.
  logic                  own_vld_q;

  logic            ld;
  logic            any;
  logic            keep;
  logic [ID_W-1:0] scan_sel;
  logic [ID_W-1:0] sel;

  // Ready is also held low while reset is asserted so no beat is taken and lost.
  assign ld   = rst_ni & ~clear_i & (~pop_valid_q | pop_ready_i);
  assign any  = |push_valid_i;
  assign keep = own_vld_q & push_valid_i[own_q] & (cnt_q < CNT_W'(MAX_BURST));

  // NOTE: every signal written here gets a default first, so no latch is inferred
  // on paths where the scan finds nothing.
  always_comb begin
    logic found;
    int   idx;
    scan_sel = own_q;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= int'(NB_IN); k++) begin
      idx = (int'(own_q) + k) % int'(NB_IN);
      if (!found && push_valid_i[idx]) begin
        scan_sel = ID_W'(idx);
        found    = 1'b1;
      end
    end
  end

  assign sel = keep ? own_q : scan_sel;

  always_comb begin
    push_ready_o = '0;
    if (ld && any) begin
      push_ready_o[sel] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
      pop_strb_q  <= '0;
      pop_id_q    <= '0;
      own_q       <= ID_W'(NB_IN - 1);
      cnt_q       <= '0;
      own_vld_q   <= 1'b0;
    end else if (clear_i) begin
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
      pop_strb_q  <= '0;
      pop_id_q    <= '0;
      own_q       <= ID_W'(NB_IN - 1);
      cnt_q       <= '0;
      own_vld_q   <= 1'b0;
    end else if (ld) begin
      if (any) begin
        pop_valid_q <= 1'b1;
        pop_data_q  <= push_data_i[sel*DATA_WIDTH +: DATA_WIDTH];
        pop_strb_q  <= push_strb_i[sel*STRB_W +: STRB_W];
        pop_id_q    <= sel;
        own_q       <= sel;
        own_vld_q   <= 1'b1;
        // A re-selection through the scan always opens a new burst.
        cnt_q       <= keep ? cnt_q + CNT_W'(1) : CNT_W'(1);
      end else begin
        pop_valid_q <= 1'b0;
        cnt_q       <= '0;
      end
    end
  end

  assign pop_valid_o = pop_valid_q;
  assign pop_data_o  = pop_data_q;
  assign pop_strb_o  = pop_strb_q;
  assign pop_id_o    = pop_id_q;

endmodule
